// File: rtl/dice_pkg.sv
// Shared types and default sizing for the dice roll button conditioner.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } roll_state_t;

    localparam int DICE_DEBOUNCE_CYCLES = 4;
    localparam int DICE_REPEAT_CYCLES   = 0;
    localparam int DICE_COUNT_W         = 8;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for asynchronous inputs; clears to 0 on reset.
module btn_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dice_roll_button.sv
// Roll button conditioner: synchronize, debounce, optional hold-to-repeat,
// and emit a one-cycle roll strobe plus a wrapping roll counter.
module dice_roll_button
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DICE_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DICE_REPEAT_CYCLES,
    parameter int COUNT_W         = DICE_COUNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_raw,
    input  logic               roll_en,
    output logic               btn_clean,
    output logic               roll_pulse,
    output logic [COUNT_W-1:0] roll_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]      CNT_DONE  = CW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0]      REP_ONE   = RW'(1);
    localparam logic [RW-1:0]      REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic          btn_sync;
    roll_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          accept, rep_fire;
    logic          clean_nxt, pulse_nxt;

    btn_sync2 #(.WIDTH(1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw),
        .q       (btn_sync)
    );

    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rep_cnt    <= '0;
            btn_clean  <= 1'b0;
            roll_pulse <= 1'b0;
            roll_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rep_cnt    <= rep_nxt;
            btn_clean  <= clean_nxt;
            roll_pulse <= pulse_nxt;
            if (roll_pulse)
                roll_count <= roll_count + COUNT_ONE;
        end
    end

    // cnt holds the run length of samples disagreeing with the accepted level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_nxt   = rep_cnt;
        accept    = 1'b0;
        rep_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    accept = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_nxt  = '0;
                        rep_fire = 1'b1;
                    end else begin
                        rep_nxt = rep_cnt + REP_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (accept) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            rep_nxt   = '0;
        end
    end

    // roll_en only gates emission; the debounce path keeps running regardless.
    always_comb begin
        clean_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
        pulse_nxt = roll_en && (accept || rep_fire);
    end

endmodule
